// File: rtl/seq_normalizer_if.sv
// seq_normalizer_if: start/ready/done handshake plus the data and result
// signals of the iterative normaliser, bundled for the seq_normalizer ports.
// The master modport belongs to the block that issues requests. The slave
// modport belongs to the normaliser itself.
interface seq_normalizer_if #(
    parameter int N = 3
);
    localparam int W = 2 ** N;

    // request side
    logic           start;
    logic [W-1:0]   a;
    logic           lr;

    // status and result side
    logic           ready;
    logic           done;
    logic [W-1:0]   y;
    logic [N-1:0]   amt;
    logic           zero;
    logic           busy_err;

    modport master (
        output start, a, lr,
        input  ready, done, y, amt, zero, busy_err
    );

    modport slave (
        input  start, a, lr,
        output ready, done, y, amt, zero, busy_err
    );
endinterface

// File: rtl/seq_normalizer.sv
// seq_normalizer: iterative shift-amount finder.
//
// The block shifts a word one bit per cycle until it is normalised:
//   - for a left request (lr=0), the MSB is set.
//   - for a right request (lr=1), the LSB is set.
// It then reports the normalised word (y) and the number of positions shifted
// (amt). A barrel shifter can reproduce the result from these outputs. An
// all-zero input is reported through zero. The results are registered and
// hold until the next result is written.
//
// Optional feature: define SEQ_NORMALIZER_BUSY_ERR_EN to build the sticky
// busy_err flag. The flag sets after start is seen while ready is low. When
// the macro is undefined, busy_err is a constant 0.
module seq_normalizer #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             reset,
    seq_normalizer_if.slave  bus
);
    localparam int W = 2 ** N;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;

    // working copy of the operand, its direction and the running shift count
    logic [W-1:0]   work_q, work_d;
    logic [N-1:0]   cnt_q,  cnt_d;
    logic           lr_q,   lr_d;

    // registered results, held between operations
    logic [W-1:0]   y_q,    y_d;
    logic [N-1:0]   amt_q,  amt_d;
    logic           zero_q, zero_d;

    // one-position shifted versions of the working word, zero-filled
    logic [W-1:0]   shl_w;
    logic [W-1:0]   shr_w;

    // status of the working word, used both by the FSM and the datapath
    logic           work_is_zero;
    logic           work_is_norm;

    // Build the single-step shifters bit by bit. The end bits take a zero fill.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_shift
            if (gi == 0) begin : g_shl_fill
                assign shl_w[gi] = 1'b0;
            end else begin : g_shl_bit
                assign shl_w[gi] = work_q[gi-1];
            end

            if (gi == W - 1) begin : g_shr_fill
                assign shr_w[gi] = 1'b0;
            end else begin : g_shr_bit
                assign shr_w[gi] = work_q[gi+1];
            end
        end
    endgenerate

    assign work_is_zero = ~|work_q;
    assign work_is_norm = lr_q ? work_q[0] : work_q[W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // The zero test comes before the normalised test. This order ensures
    // that an all-zero word can never loop in SHIFT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (work_is_zero || work_is_norm) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: the handshake is decoded directly from the state register.
    always_comb begin
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            S_IDLE:  bus.ready = 1'b1;
            S_DONE:  bus.done  = 1'b1;
            default: begin
                bus.ready = 1'b0;
                bus.done  = 1'b0;
            end
        endcase
    end

    // Datapath next state.
    // A new start loads the work register but leaves the previous results
    // untouched. Results are written only when SHIFT terminates.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        lr_d   = lr_q;
        y_d    = y_q;
        amt_d  = amt_q;
        zero_d = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    work_d = bus.a;
                    lr_d   = bus.lr;
                    cnt_d  = '0;
                end
            end
            S_SHIFT: begin
                if (work_is_zero) begin
                    zero_d = 1'b1;
                    y_d    = '0;
                    amt_d  = '0;
                end else if (work_is_norm) begin
                    zero_d = 1'b0;
                    y_d    = work_q;
                    amt_d  = cnt_q;
                end else begin
                    // A non-zero word normalises within W-1 steps, so the
                    // N-bit count cannot wrap.
                    work_d = lr_q ? shr_w : shl_w;
                    cnt_d  = cnt_q + N'(1);
                end
            end
            default: begin
                work_d = work_q;
            end
        endcase
    end

    // Datapath registers.
    // A reset clears everything, including any operation that is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            cnt_q  <= '0;
            lr_q   <= 1'b0;
            y_q    <= '0;
            amt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            lr_q   <= lr_d;
            y_q    <= y_d;
            amt_q  <= amt_d;
            zero_q <= zero_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.amt  = amt_q;
    assign bus.zero = zero_q;

`ifdef SEQ_NORMALIZER_BUSY_ERR_EN
    logic busy_err_q, busy_err_d;

    // Misuse detection: start is raised while not ready (SHIFT or DONE).
    always_comb begin
        busy_err_d = busy_err_q | (bus.start & (state_q != S_IDLE));
    end

    // Sticky flag register; only a reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_err_q <= 1'b0;
        end else begin
            busy_err_q <= busy_err_d;
        end
    end

    assign bus.busy_err = busy_err_q;
`else
    assign bus.busy_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_normalizer.sv
// tb_seq_normalizer: directed bench for seq_normalizer with N=3.
// Expected results and latencies are worked out by hand from the operands.
module tb_seq_normalizer;
    localparam int N = 3;

`ifdef SEQ_NORMALIZER_BUSY_ERR_EN
    localparam logic BE_EXP = 1'b1;
`else
    localparam logic BE_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    int   n;
    int   done_cnt;

    always #5 clk = ~clk;

    seq_normalizer_if #(.N(N)) bus ();

    seq_normalizer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count negedges until done is seen, with a bound of 40 cycles.
    // The first negedge falls in cycle T+1, so n equals the latency.
    task automatic wait_done(input bit drop_start, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (drop_start && cnt == 1) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && cnt < 40);
    endtask

    task automatic run_op(input logic [7:0] a, input logic lr, input logic [7:0] ey,
                          input logic [2:0] eamt, input logic ez, input int elat,
                          input string tag);
        int lat;
        @(negedge clk);
        bus.a     = a;
        bus.lr    = lr;
        bus.start = 1'b1;
        wait_done(1'b1, lat);
        $display("op %s: a=%02h lr=%0b -> y=%02h amt=%0d zero=%0b latency=%0d",
                 tag, a, lr, bus.y, bus.amt, bus.zero, lat);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " done"}, bus.done, 1'b1);
        chk({tag, " ready in done"}, bus.ready, 1'b0);
        chk({tag, " y"}, bus.y, ey);
        chk({tag, " amt"}, bus.amt, eamt);
        chk({tag, " zero"}, bus.zero, ez);
        @(negedge clk);
        chk({tag, " done one cycle"}, bus.done, 1'b0);
        chk({tag, " ready after"}, bus.ready, 1'b1);
        chk({tag, " y held"}, bus.y, ey);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.lr    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset ready", bus.ready, 1'b1);
        chk("reset done", bus.done, 1'b0);
        chk("reset y", bus.y, 8'h00);
        chk("reset amt", bus.amt, 3'd0);
        chk("reset zero", bus.zero, 1'b0);
        chk("reset busy_err", bus.busy_err, 1'b0);

        // Main function, with the boundary cases
        run_op(8'b0001_0110, 1'b0, 8'b1011_0000, 3'd3, 1'b0, 5, "16 left");
        run_op(8'b0001_0110, 1'b1, 8'b0000_1011, 3'd1, 1'b0, 3, "16 right");
        run_op(8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 2, "zero left");
        run_op(8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 2, "zero right");
        run_op(8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 9, "01 left");
        run_op(8'h80, 1'b1, 8'h01, 3'd7, 1'b0, 9, "80 right");
        run_op(8'h80, 1'b0, 8'h80, 3'd0, 1'b0, 2, "80 left");

        // Held start: back-to-back operations with one IDLE cycle between them
        @(negedge clk);
        bus.a     = 8'h40;
        bus.lr    = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (i == 0 && n == 1) begin
                    chk("held prev y kept", bus.y, 8'h80);
                    chk("held prev amt kept", bus.amt, 3'd0);
                end
            end while (bus.done !== 1'b1 && n < 40);
            $display("op held#%0d: a=40 lr=0 -> y=%02h amt=%0d zero=%0b gap=%0d",
                     i, bus.y, bus.amt, bus.zero, n);
            chk("held gap", n, (i == 0) ? 3 : 4);
            chk("held y", bus.y, 8'h80);
            chk("held amt", bus.amt, 3'd1);
            if (i == 2) bus.start = 1'b0;
        end
        @(negedge clk);
        chk("held end ready", bus.ready, 1'b1);
        chk("held end done", bus.done, 1'b0);
        @(negedge clk);
        chk("held stays idle", bus.ready, 1'b1);
        chk("held busy_err", bus.busy_err, BE_EXP);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.a     = 8'h01;
        bus.lr    = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("op abort: reset during shift -> ready=%0b y=%02h amt=%0d",
                 bus.ready, bus.y, bus.amt);
        chk("abort ready", bus.ready, 1'b1);
        chk("abort done", bus.done, 1'b0);
        chk("abort y", bus.y, 8'h00);
        chk("abort amt", bus.amt, 3'd0);
        chk("abort zero", bus.zero, 1'b0);
        chk("abort busy_err", bus.busy_err, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        chk("abort no done", done_cnt, 0);
        run_op(8'b0001_0110, 1'b0, 8'b1011_0000, 3'd3, 1'b0, 5, "after abort");

        // Start pulse during SHIFT is ignored
        chk("pre busy_err", bus.busy_err, 1'b0);
        @(negedge clk);
        bus.a     = 8'h01;
        bus.lr    = 1'b0;
        bus.start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (n == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.lr    = 1'b1;
            end
            if (n == 3) begin
                bus.start = 1'b0;
                chk("busy_err set", bus.busy_err, BE_EXP);
            end
        end while (bus.done !== 1'b1 && n < 40);
        $display("op busy: a=01 lr=0 (FF pulsed) -> y=%02h amt=%0d zero=%0b latency=%0d busy_err=%0b",
                 bus.y, bus.amt, bus.zero, n, bus.busy_err);
        chk("busy latency", n, 9);
        chk("busy y", bus.y, 8'h80);
        chk("busy amt", bus.amt, 3'd7);
        chk("busy zero", bus.zero, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_err sticky", bus.busy_err, BE_EXP);
        chk("busy ready", bus.ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy_err cleared", bus.busy_err, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
